// File: rtl/vga_blit_pkg.sv
// vga_blit_pkg: shared definitions for the rectangle blitter.
//   - FSM state enum
//   - bus register map (base address and offsets for X0, Y0, X1, Y1, CMD)
//   - CMD bit positions
//   - frame buffer geometry and address width
//   - pixel colour helper
package vga_blit_pkg;

  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned ADDR_W = X_W + Y_W;

  localparam logic [7:0] BASE_ADDR = 8'hB4;
  localparam logic [7:0] OFF_X0    = 8'd0;
  localparam logic [7:0] OFF_Y0    = 8'd1;
  localparam logic [7:0] OFF_X1    = 8'd2;
  localparam logic [7:0] OFF_Y1    = 8'd3;
  localparam logic [7:0] OFF_CMD   = 8'd4;

  localparam int unsigned CMD_COLOUR_BIT = 0;
  localparam int unsigned CMD_MODE_BIT   = 1;
  localparam int unsigned CMD_ABORT_BIT  = 7;

  localparam logic [7:0] X_MAX = 8'd159;
  localparam logic [7:0] Y_MAX = 8'd119;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } blit_state_t;

  // Solid mode returns the colour; chequer mode flips it on odd x+y parity.
  function automatic logic pixel_value(input logic colour, input logic mode,
                                       input logic x_lsb, input logic y_lsb);
    return colour ^ (mode & (x_lsb ^ y_lsb));
  endfunction

endpackage

// File: rtl/vga_rect_blitter_if.sv
// vga_rect_blitter_if: processor write bus plus frame buffer port A.
//   master: processor side (drives BUS_*, observes FB_*)
//   slave : blitter side (observes BUS_*, drives FB_*)
//   BUS_ADDR[7:0], BUS_DATA[7:0], BUS_WE  - processor register writes
//   FB_ADDR[14:0] = {y[6:0], x[7:0]}, FB_DATA, FB_WE - pixel write port
interface vga_rect_blitter_if;

  logic [7:0]                      BUS_ADDR;
  logic [7:0]                      BUS_DATA;
  logic                            BUS_WE;
  logic [vga_blit_pkg::ADDR_W-1:0] FB_ADDR;
  logic                            FB_DATA;
  logic                            FB_WE;

  modport master (
    output BUS_ADDR, BUS_DATA, BUS_WE,
    input  FB_ADDR, FB_DATA, FB_WE
  );

  modport slave (
    input  BUS_ADDR, BUS_DATA, BUS_WE,
    output FB_ADDR, FB_DATA, FB_WE
  );

endinterface

// File: rtl/vga_blit_regs.sv
// vga_blit_regs: bus decode and shadow registers for the blitter.
//   clk_i, rst_i            - clock, synchronous active-high reset
//   addr_i, data_i, we_i    - processor write bus
//   x0_o, y0_o, x1_o, y1_o  - shadow corner registers
//   colour_o, mode_o        - CMD colour/mode as seen this cycle (write-through)
//   start_o                 - CMD write with abort bit clear (single bus cycle)
//   abort_o                 - CMD write with abort bit set (single bus cycle)
module vga_blit_regs
  import vga_blit_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  input  logic       we_i,
  output logic [7:0] x0_o,
  output logic [7:0] y0_o,
  output logic [7:0] x1_o,
  output logic [7:0] y1_o,
  output logic       colour_o,
  output logic       mode_o,
  output logic       start_o,
  output logic       abort_o
);

  logic [7:0] off;
  logic       wr_x0, wr_y0, wr_x1, wr_y1, wr_cmd;
  logic [7:0] x0_q, y0_q, x1_q, y1_q, cmd_q, cmd_d;

  // Offset from the base; addresses below the base wrap high and miss.
  assign off    = addr_i - BASE_ADDR;
  assign wr_x0  = we_i && (off == OFF_X0);
  assign wr_y0  = we_i && (off == OFF_Y0);
  assign wr_x1  = we_i && (off == OFF_X1);
  assign wr_y1  = we_i && (off == OFF_Y1);
  assign wr_cmd = we_i && (off == OFF_CMD);

  // The command is consumed in the same cycle it is written, so the engine
  // sees the incoming byte rather than the stored one.
  assign cmd_d = wr_cmd ? data_i : cmd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x0_q  <= '0;
      y0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
      cmd_q <= '0;
    end else begin
      if (wr_x0) x0_q <= data_i;
      if (wr_y0) y0_q <= data_i;
      if (wr_x1) x1_q <= data_i;
      if (wr_y1) y1_q <= data_i;
      cmd_q <= cmd_d;
    end
  end

  assign x0_o     = x0_q;
  assign y0_o     = y0_q;
  assign x1_o     = x1_q;
  assign y1_o     = y1_q;
  assign colour_o = cmd_d[CMD_COLOUR_BIT];
  assign mode_o   = cmd_d[CMD_MODE_BIT];
  assign start_o  = wr_cmd && !data_i[CMD_ABORT_BIT];
  assign abort_o  = wr_cmd &&  data_i[CMD_ABORT_BIT];

endmodule

// File: rtl/vga_rect_blitter.sv
// vga_rect_blitter: rectangle fill engine driving frame buffer port A.
//   CLK, RESET   - clock, synchronous active-high reset
//   bus          - slave side of vga_rect_blitter_if (processor bus in,
//                  frame buffer write port out)
//   BUSY         - high whenever the engine is not IDLE
//   DONE_IRQ     - one-cycle pulse when an operation ends
// The x/y counters always hold the coordinate of the pixel currently on
// FB_ADDR, so the final pixel is recognised while it is being presented.
module vga_rect_blitter
  import vga_blit_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  vga_rect_blitter_if.slave bus,
  output logic              BUSY,
  output logic              DONE_IRQ
);

  logic [7:0] sh_x0, sh_y0, sh_x1, sh_y1;
  logic       sh_colour, sh_mode, start, abort;

  vga_blit_regs u_regs (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .addr_i   (bus.BUS_ADDR),
    .data_i   (bus.BUS_DATA),
    .we_i     (bus.BUS_WE),
    .x0_o     (sh_x0),
    .y0_o     (sh_y0),
    .x1_o     (sh_x1),
    .y1_o     (sh_y1),
    .colour_o (sh_colour),
    .mode_o   (sh_mode),
    .start_o  (start),
    .abort_o  (abort)
  );

  blit_state_t       state_q;
  logic [7:0]        x0_q, y0_q, x1_q, y1_q;
  logic              colour_q, mode_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic              fb_data_q, fb_we_q, busy_q, done_q;

  logic [7:0]        x1_clip, y1_clip;
  logic              empty, row_end, last_pix;
  logic [X_W-1:0]    x_nx;
  logic [Y_W-1:0]    y_nx;

  always_comb begin
    x1_clip  = (x1_q > X_MAX) ? X_MAX : x1_q;
    y1_clip  = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    empty    = (x0_q > x1_clip) || (y0_q > y1_clip);
    // In RUN, x1_q/y1_q already hold the clipped limits.
    row_end  = (x_q == x1_q);
    last_pix = row_end && ({1'b0, y_q} == y1_q);
    x_nx     = row_end ? x0_q : x_q + 8'd1;
    y_nx     = row_end ? y_q + 7'd1 : y_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      colour_q  <= 1'b0;
      mode_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fb_addr_q <= '0;
      fb_data_q <= 1'b0;
      fb_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fb_we_q <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            state_q  <= CLIP;
            busy_q   <= 1'b1;
            x0_q     <= sh_x0;
            y0_q     <= sh_y0;
            x1_q     <= sh_x1;
            y1_q     <= sh_y1;
            colour_q <= sh_colour;
            mode_q   <= sh_mode;
          end
        end
        CLIP: begin
          if (abort || empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= RUN;
            x1_q      <= x1_clip;
            y1_q      <= y1_clip;
            x_q       <= x0_q;
            y_q       <= y0_q[Y_W-1:0];
            fb_we_q   <= 1'b1;
            fb_addr_q <= {y0_q[Y_W-1:0], x0_q};
            fb_data_q <= pixel_value(colour_q, mode_q, x0_q[0], y0_q[0]);
          end
        end
        RUN: begin
          if (abort || last_pix) begin
            state_q <= DONE;
            fb_we_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            x_q       <= x_nx;
            y_q       <= y_nx;
            fb_addr_q <= {y_nx, x_nx};
            fb_data_q <= pixel_value(colour_q, mode_q, x_nx[0], y_nx[0]);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.FB_ADDR = fb_addr_q;
  assign bus.FB_DATA = fb_data_q;
  assign bus.FB_WE   = fb_we_q;
  assign BUSY        = busy_q;
  assign DONE_IRQ    = done_q;

endmodule
